// File: rtl/serial_pattern_tx_if.sv
// Load handshake and serial-side signals of serial_pattern_tx.
// With PATTERN_LOOP_EN defined the loop request input is added.
interface serial_pattern_tx_if #(
  parameter int WIDTH = 8,
  parameter int LENW  = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [LENW-1:0]  load_len;
  logic             tx_en;
  logic             x_out;
  logic             x_valid;
  logic             busy;
  logic             done;
`ifdef PATTERN_LOOP_EN
  logic             loop;
`endif

  modport master (
`ifdef PATTERN_LOOP_EN
    output loop,
`endif
    output load_valid, load_data, load_len, tx_en,
    input  load_ready, x_out, x_valid, busy, done
  );

  modport slave (
`ifdef PATTERN_LOOP_EN
    input  loop,
`endif
    input  load_valid, load_data, load_len, tx_en,
    output load_ready, x_out, x_valid, busy, done
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a left-aligned pattern out MSB first with an
// idle gap between frames. PATTERN_LOOP_EN adds automatic frame repetition.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LENW  = 4,
  parameter int GAP   = 0
) (
  input logic            clk,
  input logic            rst_n,
  serial_pattern_tx_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  localparam int              GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0]   GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [LENW-1:0] WIDTH_L  = LENW'(WIDTH);

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [LENW-1:0]  remaining, rem_d;
  logic [GW-1:0]    gap_cnt, gap_d;
  logic             done_q, done_d;
  logic [LENW-1:0]  len_eff;
  logic [WIDTH-1:0] aligned;
`ifdef PATTERN_LOOP_EN
  logic [WIDTH-1:0] save_shreg, save_shreg_d;
  logic [LENW-1:0]  save_len, save_len_d;
  logic             loop_q, loop_d;
`endif

  always_comb begin
    len_eff = (bus.load_len > WIDTH_L) ? WIDTH_L : bus.load_len;
    aligned = bus.load_data << (WIDTH_L - len_eff);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shreg     <= '0;
      remaining <= '0;
      gap_cnt   <= '0;
      done_q    <= 1'b0;
`ifdef PATTERN_LOOP_EN
      save_shreg <= '0;
      save_len   <= '0;
      loop_q     <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      remaining <= rem_d;
      gap_cnt   <= gap_d;
      done_q    <= done_d;
`ifdef PATTERN_LOOP_EN
      save_shreg <= save_shreg_d;
      save_len   <= save_len_d;
      loop_q     <= loop_d;
`endif
    end
  end

  always_comb begin
    state_d        = state;
    shreg_d        = shreg;
    rem_d          = remaining;
    gap_d          = gap_cnt;
    done_d         = 1'b0;
`ifdef PATTERN_LOOP_EN
    save_shreg_d   = save_shreg;
    save_len_d     = save_len;
    loop_d         = loop_q;
`endif
    bus.load_ready = (state == S_IDLE);
    bus.busy       = (state != S_IDLE);
    bus.x_out      = 1'b0;
    bus.x_valid    = 1'b0;
    bus.done       = done_q;

    case (state)
      S_IDLE: begin
        if (bus.load_valid) begin
          shreg_d = aligned;
          rem_d   = len_eff;
`ifdef PATTERN_LOOP_EN
          save_shreg_d = aligned;
          save_len_d   = len_eff;
`endif
          // A zero-length frame completes at once and never enters the gap.
          if (len_eff == '0) done_d = 1'b1;
          else               state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bus.x_out   = shreg[WIDTH-1];
        bus.x_valid = bus.tx_en;
        if (bus.tx_en) begin
          shreg_d = shreg << 1;
          rem_d   = remaining - LENW'(1);
          if (remaining == LENW'(1)) begin
            done_d = 1'b1;
`ifdef PATTERN_LOOP_EN
            loop_d = bus.loop;
`endif
            if (GAP > 0) begin
              state_d = S_GAP;
              gap_d   = GAP_LAST;
            end else begin
              state_d = S_IDLE;
`ifdef PATTERN_LOOP_EN
              // Without a gap the repeat starts on the very next cycle.
              if (bus.loop) begin
                state_d = S_SHIFT;
                shreg_d = save_shreg;
                rem_d   = save_len;
              end
`endif
            end
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          state_d = S_IDLE;
`ifdef PATTERN_LOOP_EN
          if (loop_q) begin
            state_d = S_SHIFT;
            shreg_d = save_shreg;
            rem_d   = save_len;
          end
`endif
        end else begin
          gap_d = gap_cnt - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule
